// File: rtl/hazard_unit_md.sv
// ---------------------------------------------------------------------------
// hazard_unit_md
// Hazard unit for a 5-stage MIPS pipeline (F/D/E/M/W) using a Tuse/Tnew
// scheme. It decodes the four in-flight instructions and produces the
// stall/bubble controls and every forwarding-mux select. It also tracks the
// multi-cycle multiply/divide unit and counts stalled cycles.
//
// Ports
//   clk         pipeline clock, rising edge
//   reset       asynchronous, active-low reset
//   IR_D..IR_W  instruction words held in D, E, M, W (0 = nop)
//   PC_en       PC write enable            (low while stalling)
//   IR_D_en     F/D register enable        (low while stalling)
//   IR_E_clr    D/E synchronous clear      (bubble insert while stalling)
//   md_busy     multiply/divide unit busy
//   ForwardRSD/RTD/RSE/RTE/RTM  forwarding selects:
//               0 regfile, 1 M result, 2 W data, 3 E PC+8, 4 M PC+8, 5 W PC+8
//   stall_cnt   saturating count of stalled cycles since reset
// ---------------------------------------------------------------------------
module hazard_unit_md #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      IR_D,
   input  logic [31:0]      IR_E,
   input  logic [31:0]      IR_M,
   input  logic [31:0]      IR_W,
   output logic             PC_en,
   output logic             IR_D_en,
   output logic             IR_E_clr,
   output logic             md_busy,
   output logic [2:0]       ForwardRSD,
   output logic [2:0]       ForwardRTD,
   output logic [2:0]       ForwardRSE,
   output logic [2:0]       ForwardRTE,
   output logic [2:0]       ForwardRTM,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [3:0] LP_MULT_LAT = 4'(MULT_LAT);
   localparam logic [3:0] LP_DIV_LAT  = 4'(DIV_LAT);

   // Consumer order: 0 rs@D, 1 rt@D, 2 rs@E, 3 rt@E, 4 rt@M (store data).
   // D consumers see producers E/M/W, E consumers M/W, the store only W.
   localparam logic [4:0] LP_USE_E = 5'b00011;
   localparam logic [4:0] LP_USE_M = 5'b01111;

   // ---------------- instruction classification ----------------
   function automatic logic f_rcal(input logic [31:0] ir);
      logic [5:0] fn;
      fn = ir[5:0];
      return (ir[31:26] == 6'h00) &&
             (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 ||
              fn == 6'h25 || fn == 6'h2A || fn == 6'h00);
   endfunction

   function automatic logic f_ical(input logic [31:0] ir);
      return ir[31:26] == 6'h0D || ir[31:26] == 6'h0F || ir[31:26] == 6'h09;
   endfunction

   function automatic logic f_lw(input logic [31:0] ir);
      return ir[31:26] == 6'h23;
   endfunction

   function automatic logic f_sw(input logic [31:0] ir);
      return ir[31:26] == 6'h2B;
   endfunction

   function automatic logic f_br(input logic [31:0] ir);
      return ir[31:26] == 6'h04 || ir[31:26] == 6'h05;
   endfunction

   function automatic logic f_jal(input logic [31:0] ir);
      return ir[31:26] == 6'h03;
   endfunction

   function automatic logic f_spec(input logic [31:0] ir, input logic [5:0] fn);
      return (ir[31:26] == 6'h00) && (ir[5:0] == fn);
   endfunction

   function automatic logic f_jr(input logic [31:0] ir);
      return f_spec(ir, 6'h08);
   endfunction

   function automatic logic f_jalr(input logic [31:0] ir);
      return f_spec(ir, 6'h09);
   endfunction

   function automatic logic f_mult(input logic [31:0] ir);
      return f_spec(ir, 6'h18) || f_spec(ir, 6'h19);
   endfunction

   function automatic logic f_div(input logic [31:0] ir);
      return f_spec(ir, 6'h1A) || f_spec(ir, 6'h1B);
   endfunction

   function automatic logic f_mf(input logic [31:0] ir);
      return f_spec(ir, 6'h10) || f_spec(ir, 6'h12);
   endfunction

   function automatic logic f_mt(input logic [31:0] ir);
      return f_spec(ir, 6'h11) || f_spec(ir, 6'h13);
   endfunction

   function automatic logic f_link(input logic [31:0] ir);
      return f_jal(ir) || f_jalr(ir);
   endfunction

   // Destination register; 0 means "writes nothing" and is never matched.
   function automatic logic [4:0] f_dst(input logic [31:0] ir);
      if (f_rcal(ir) || f_mf(ir) || f_jalr(ir)) return ir[15:11];
      if (f_ical(ir) || f_lw(ir))               return ir[20:16];
      if (f_jal(ir))                            return 5'd31;
      return 5'd0;
   endfunction

   function automatic logic f_rs_rd(input logic [31:0] ir);
      return f_rcal(ir) || f_ical(ir) || f_lw(ir) || f_sw(ir) || f_br(ir) ||
             f_jr(ir) || f_jalr(ir) || f_mult(ir) || f_div(ir) || f_mt(ir);
   endfunction

   function automatic logic f_rt_rd(input logic [31:0] ir);
      return f_rcal(ir) || f_sw(ir) || f_br(ir) || f_mult(ir) || f_div(ir);
   endfunction

   function automatic logic [1:0] f_rs_tuse(input logic [31:0] ir);
      return (f_br(ir) || f_jr(ir) || f_jalr(ir)) ? 2'd0 : 2'd1;
   endfunction

   function automatic logic [1:0] f_rt_tuse(input logic [31:0] ir);
      if (f_br(ir)) return 2'd0;
      if (f_sw(ir)) return 2'd2;
      return 2'd1;
   endfunction

   // Tnew as seen while the instruction sits in E.
   function automatic logic [1:0] f_tnew_e(input logic [31:0] ir);
      if (f_lw(ir))                            return 2'd2;
      if (f_rcal(ir) || f_ical(ir) || f_mf(ir)) return 2'd1;
      return 2'd0;
   endfunction

   // Select for one consumer. The newest matching producer decides; if its
   // value is not ready yet its code is 0 and the stall logic holds D.
   function automatic logic [2:0] f_fwd(
      input logic [4:0] r,  input logic rd,
      input logic use_e,    input logic use_m,
      input logic [4:0] de, input logic [4:0] dm, input logic [4:0] dw,
      input logic [2:0] ce, input logic [2:0] cm, input logic [2:0] cw);
      if (!rd || r == 5'd0)       return 3'd0;
      if (use_e && r == de)       return ce;
      if (use_m && r == dm)       return cm;
      if (r == dw)                return cw;
      return 3'd0;
   endfunction

   // ---------------- producer info ----------------
   logic [4:0] w_dst_e, w_dst_m, w_dst_w;
   logic [1:0] w_tnew_e, w_tnew_m;
   logic [2:0] w_code_e, w_code_m, w_code_w;

   assign w_dst_e  = f_dst(IR_E);
   assign w_dst_m  = f_dst(IR_M);
   assign w_dst_w  = f_dst(IR_W);
   assign w_tnew_e = f_tnew_e(IR_E);
   assign w_tnew_m = (f_tnew_e(IR_M) == 2'd0) ? 2'd0 : f_tnew_e(IR_M) - 2'd1;

   assign w_code_e = f_link(IR_E) ? 3'd3 : 3'd0;
   assign w_code_m = (f_rcal(IR_M) || f_ical(IR_M) || f_mf(IR_M)) ? 3'd1 :
                     f_link(IR_M) ? 3'd4 : 3'd0;
   assign w_code_w = (f_rcal(IR_W) || f_ical(IR_W) || f_mf(IR_W) || f_lw(IR_W)) ? 3'd2 :
                     f_link(IR_W) ? 3'd5 : 3'd0;

   // ---------------- stall ----------------
   logic [4:0] w_rs_d, w_rt_d;
   logic       w_hz_rs, w_hz_rt, w_data_stall, w_md_stall, w_stall;
   logic       w_md_start_e;
   logic [3:0] r_md_cnt;

   assign w_rs_d = IR_D[25:21];
   assign w_rt_d = IR_D[20:16];

   assign w_hz_rs = f_rs_rd(IR_D) && (w_rs_d != 5'd0) &&
                    ((w_rs_d == w_dst_e && f_rs_tuse(IR_D) < w_tnew_e) ||
                     (w_rs_d == w_dst_m && f_rs_tuse(IR_D) < w_tnew_m));
   assign w_hz_rt = f_rt_rd(IR_D) && (w_rt_d != 5'd0) &&
                    ((w_rt_d == w_dst_e && f_rt_tuse(IR_D) < w_tnew_e) ||
                     (w_rt_d == w_dst_m && f_rt_tuse(IR_D) < w_tnew_m));

   assign w_data_stall = w_hz_rs || w_hz_rt;
   assign w_md_start_e = f_mult(IR_E) || f_div(IR_E);
   assign md_busy      = (r_md_cnt != 4'd0) || w_md_start_e;
   assign w_md_stall   = md_busy &&
                         (f_mult(IR_D) || f_div(IR_D) || f_mf(IR_D) || f_mt(IR_D));
   assign w_stall      = w_data_stall || w_md_stall;

   assign PC_en    = !w_stall;
   assign IR_D_en  = !w_stall;
   assign IR_E_clr = w_stall;

   // ---------------- forwarding ----------------
   logic [4:0] w_c_reg [5];
   logic [4:0] w_c_rd;
   logic [2:0] w_sel   [5];

   assign w_c_reg[0] = IR_D[25:21];  assign w_c_rd[0] = f_rs_rd(IR_D);
   assign w_c_reg[1] = IR_D[20:16];  assign w_c_rd[1] = f_rt_rd(IR_D);
   assign w_c_reg[2] = IR_E[25:21];  assign w_c_rd[2] = f_rs_rd(IR_E);
   assign w_c_reg[3] = IR_E[20:16];  assign w_c_rd[3] = f_rt_rd(IR_E);
   assign w_c_reg[4] = IR_M[20:16];  assign w_c_rd[4] = f_sw(IR_M);

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_fwd
         assign w_sel[gi] = f_fwd(w_c_reg[gi], w_c_rd[gi], LP_USE_E[gi], LP_USE_M[gi],
                                  w_dst_e, w_dst_m, w_dst_w,
                                  w_code_e, w_code_m, w_code_w);
      end
   endgenerate

   assign ForwardRSD = w_sel[0];
   assign ForwardRTD = w_sel[1];
   assign ForwardRSE = w_sel[2];
   assign ForwardRTE = w_sel[3];
   assign ForwardRTM = w_sel[4];

   // ---------------- state ----------------
   // A start in E always (re)loads, even if the unit is still busy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                 r_md_cnt <= 4'd0;
      else if (f_mult(IR_E))      r_md_cnt <= LP_MULT_LAT;
      else if (f_div(IR_E))       r_md_cnt <= LP_DIV_LAT;
      else if (r_md_cnt != 4'd0)  r_md_cnt <= r_md_cnt - 4'd1;
   end

   logic [CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
   end

   assign stall_cnt = r_stall_cnt;

   // Shift-amount fields play no part in hazard detection.
   logic w_unused_shamt;
   assign w_unused_shamt = ^{IR_D[10:6], IR_E[10:6], IR_M[10:6], IR_W[10:6]};

endmodule

// File: tb/tb_hazard_unit_md.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit_md
// Directed scenarios plus randomized instruction mixes for hazard_unit_md,
// checked against a reference model built from the Tuse/Tnew rules.
// ---------------------------------------------------------------------------
module tb_hazard_unit_md;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;
   localparam int CNT_W    = 8;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [31:0]      IR_D = '0, IR_E = '0, IR_M = '0, IR_W = '0;
   logic             PC_en, IR_D_en, IR_E_clr, md_busy;
   logic [2:0]       ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, ForwardRTM;
   logic [CNT_W-1:0] stall_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int md_left  = 0;   // model: remaining busy cycles of the MD unit
   int stall_total = 0;

   hazard_unit_md #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M), .IR_W(IR_W),
      .PC_en(PC_en), .IR_D_en(IR_D_en), .IR_E_clr(IR_E_clr), .md_busy(md_busy),
      .ForwardRSD(ForwardRSD), .ForwardRTD(ForwardRTD), .ForwardRSE(ForwardRSE),
      .ForwardRTE(ForwardRTE), .ForwardRTM(ForwardRTM), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef enum int {K_NOP, K_RCAL, K_ICAL, K_LW, K_SW, K_BR, K_JR, K_JALR,
                     K_JAL, K_MULT, K_DIV, K_MF, K_MT} kind_e;

   typedef struct {
      logic stall;
      logic busy;
      int   rsd, rtd, rse, rte, rtm;
   } exp_t;

   function automatic kind_e kind_of(logic [31:0] ir);
      int op, fn;
      op = int'(ir[31:26]);
      fn = int'(ir[5:0]);
      if (op == 0) begin
         case (fn)
            'h21, 'h23, 'h24, 'h25, 'h2A, 'h00: return K_RCAL;
            'h08: return K_JR;
            'h09: return K_JALR;
            'h18, 'h19: return K_MULT;
            'h1A, 'h1B: return K_DIV;
            'h10, 'h12: return K_MF;
            'h11, 'h13: return K_MT;
            default: return K_NOP;
         endcase
      end
      case (op)
         'h0D, 'h0F, 'h09: return K_ICAL;
         'h23: return K_LW;
         'h2B: return K_SW;
         'h04, 'h05: return K_BR;
         'h03: return K_JAL;
         default: return K_NOP;
      endcase
   endfunction

   // Tuse of an operand (which_rt selects rt), or -1 when it is not read.
   function automatic int tuse_of(logic [31:0] ir, bit which_rt);
      case (kind_of(ir))
         K_RCAL, K_MULT, K_DIV: return 1;
         K_ICAL, K_LW, K_MT:    return which_rt ? -1 : 1;
         K_SW:                  return which_rt ? 2 : 1;
         K_BR:                  return 0;
         K_JR, K_JALR:          return which_rt ? -1 : 0;
         default:               return -1;
      endcase
   endfunction

   function automatic int dest_of(logic [31:0] ir);
      case (kind_of(ir))
         K_RCAL, K_MF, K_JALR: return int'(ir[15:11]);
         K_ICAL, K_LW:         return int'(ir[20:16]);
         K_JAL:                return 31;
         default:              return 0;
      endcase
   endfunction

   // Cycles until the result exists, for stage 0=E, 1=M, 2=W.
   function automatic int tnew_in(logic [31:0] ir, int stage);
      int base;
      case (kind_of(ir))
         K_LW:                base = 2;
         K_RCAL, K_ICAL, K_MF: base = 1;
         default:             base = 0;
      endcase
      return (base - stage > 0) ? base - stage : 0;
   endfunction

   // Mux code a producer offers at this stage, -1 when not yet available.
   function automatic int code_of(logic [31:0] ir, int stage);
      kind_e k;
      k = kind_of(ir);
      if (k == K_JAL || k == K_JALR) return 3 + stage;
      if (stage > 0 && tnew_in(ir, stage) == 0 &&
          (k == K_RCAL || k == K_ICAL || k == K_MF || k == K_LW)) return stage;
      return -1;
   endfunction

   function automatic int fwd_model(int r, bit reads, int first_stage);
      logic [31:0] pipe [3];
      int c;
      pipe[0] = IR_E; pipe[1] = IR_M; pipe[2] = IR_W;
      if (!reads || r == 0) return 0;
      for (int s = first_stage; s < 3; s++) begin
         if (dest_of(pipe[s]) == r) begin
            c = code_of(pipe[s], s);
            return (c < 0) ? 0 : c;
         end
      end
      return 0;
   endfunction

   function automatic exp_t model();
      exp_t x;
      logic [31:0] pipe [2];
      int ops [2], tus [2];
      kind_e kd;
      bit data_st;
      pipe[0] = IR_E; pipe[1] = IR_M;
      ops[0] = int'(IR_D[25:21]); tus[0] = tuse_of(IR_D, 1'b0);
      ops[1] = int'(IR_D[20:16]); tus[1] = tuse_of(IR_D, 1'b1);
      data_st = 1'b0;
      for (int o = 0; o < 2; o++)
         for (int s = 0; s < 2; s++)
            if (tus[o] >= 0 && ops[o] != 0 && dest_of(pipe[s]) == ops[o] &&
                tus[o] < tnew_in(pipe[s], s))
               data_st = 1'b1;
      kd = kind_of(IR_D);
      x.busy  = (md_left > 0) || kind_of(IR_E) inside {K_MULT, K_DIV};
      x.stall = data_st || (x.busy && kd inside {K_MULT, K_DIV, K_MF, K_MT});
      x.rsd = fwd_model(int'(IR_D[25:21]), tuse_of(IR_D, 1'b0) >= 0, 0);
      x.rtd = fwd_model(int'(IR_D[20:16]), tuse_of(IR_D, 1'b1) >= 0, 0);
      x.rse = fwd_model(int'(IR_E[25:21]), tuse_of(IR_E, 1'b0) >= 0, 1);
      x.rte = fwd_model(int'(IR_E[20:16]), tuse_of(IR_E, 1'b1) >= 0, 1);
      x.rtm = fwd_model(int'(IR_M[20:16]), kind_of(IR_M) == K_SW, 2);
      return x;
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic logic [31:0] r_ins(int fn, int rs, int rt, int rd);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic int rreg();
      int v;
      v = int'($urandom_range(0, 4));
      return (v == 4) ? 31 : v;
   endfunction

   function automatic logic [31:0] rand_ins();
      int rs, rt, rd;
      rs = rreg(); rt = rreg(); rd = rreg();
      case ($urandom_range(0, 15))
         0:  return 32'd0;
         1:  return r_ins('h21, rs, rt, rd);
         2:  return r_ins('h2A, rs, rt, rd);
         3:  return i_ins('h0D, rs, rt, 5);
         4:  return i_ins('h0F, 0, rt, 1);
         5:  return i_ins('h23, rs, rt, 4);
         6:  return i_ins('h2B, rs, rt, 8);
         7:  return i_ins('h04 + int'($urandom_range(0, 1)), rs, rt, 2);
         8:  return r_ins('h08, rs, 0, 0);
         9:  return r_ins('h09, rs, 0, rd);
         10: return {6'h03, 26'h40};
         11: return r_ins('h18 + int'($urandom_range(0, 1)), rs, rt, 0);
         12: return r_ins('h1A + int'($urandom_range(0, 1)), rs, rt, 0);
         13: return r_ins('h10 + 2 * int'($urandom_range(0, 1)), 0, 0, rd);
         14: return r_ins('h11 + 2 * int'($urandom_range(0, 1)), rs, 0, 0);
         default: return $urandom;
      endcase
   endfunction

   task automatic drive(logic [31:0] d, logic [31:0] e, logic [31:0] m, logic [31:0] w);
      IR_D = d; IR_E = e; IR_M = m; IR_W = w;
      #1;
   endtask

   // One clock: the model state advances with the inputs seen before the edge.
   task automatic tick();
      exp_t x;
      kind_e ke;
      x  = model();
      ke = kind_of(IR_E);
      @(posedge clk);
      if (ke == K_MULT)      md_left = MULT_LAT;
      else if (ke == K_DIV)  md_left = DIV_LAT;
      else if (md_left > 0)  md_left--;
      if (x.stall && stall_total < CNT_MAX) stall_total++;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      drive(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      md_left = 0;
      stall_total = 0;
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      drive(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      n_checks++; if (PC_en !== 1'b1)    $display("FAIL rst_pc_en: got %b want 1", PC_en);       else n_pass++;
      n_checks++; if (IR_D_en !== 1'b1)  $display("FAIL rst_ir_d_en: got %b want 1", IR_D_en);   else n_pass++;
      n_checks++; if (IR_E_clr !== 1'b0) $display("FAIL rst_ir_e_clr: got %b want 0", IR_E_clr); else n_pass++;
      n_checks++; if (md_busy !== 1'b0)  $display("FAIL rst_md_busy: got %b want 0", md_busy);   else n_pass++;
      n_checks++; if (stall_cnt !== '0)  $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
      n_checks++;
      if ({ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, ForwardRTM} !== 15'd0)
         $display("FAIL rst_forwards: got %0d %0d %0d %0d %0d want all 0",
                  ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, ForwardRTM);
      else n_pass++;
      reset = 1'b1;
      md_left = 0; stall_total = 0;
      tick();
      n_checks++; if (stall_cnt !== '0)  $display("FAIL rst_idle_cnt: got %0d want 0", stall_cnt); else n_pass++;
   endtask

   task automatic test_load_use();
      logic [31:0] lw1, addu3;
      lw1   = i_ins('h23, 4, 1, 0);
      addu3 = r_ins('h21, 1, 2, 3);
      do_reset();
      drive(addu3, lw1, 0, 0);
      n_checks++; if (PC_en !== 1'b0)    $display("FAIL lu_pc_en: got %b want 0", PC_en);       else n_pass++;
      n_checks++; if (IR_D_en !== 1'b0)  $display("FAIL lu_ir_d_en: got %b want 0", IR_D_en);   else n_pass++;
      n_checks++; if (IR_E_clr !== 1'b1) $display("FAIL lu_ir_e_clr: got %b want 1", IR_E_clr); else n_pass++;
      tick();
      n_checks++; if (stall_cnt !== 8'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); else n_pass++;
      drive(addu3, 0, lw1, 0);
      n_checks++; if (PC_en !== 1'b1)    $display("FAIL lu_m_pc_en: got %b want 1", PC_en);      else n_pass++;
      n_checks++; if (ForwardRSD !== 3'd0) $display("FAIL lu_m_rsd: got %0d want 0", ForwardRSD); else n_pass++;
      tick();
      drive(0, addu3, 0, lw1);
      n_checks++; if (ForwardRSE !== 3'd2) $display("FAIL lu_rse: got %0d want 2", ForwardRSE);   else n_pass++;
      n_checks++; if (ForwardRTE !== 3'd0) $display("FAIL lu_rte: got %0d want 0", ForwardRTE);   else n_pass++;
      tick();
   endtask

   task automatic test_branch_fwd();
      logic [31:0] ori5, beq5;
      ori5 = i_ins('h0D, 0, 5, 1);
      beq5 = i_ins('h04, 5, 0, 3);
      do_reset();
      drive(beq5, ori5, 0, 0);
      n_checks++; if (PC_en !== 1'b0)    $display("FAIL br_pc_en: got %b want 0", PC_en);       else n_pass++;
      n_checks++; if (IR_E_clr !== 1'b1) $display("FAIL br_ir_e_clr: got %b want 1", IR_E_clr); else n_pass++;
      tick();
      drive(beq5, 0, ori5, 0);
      n_checks++; if (PC_en !== 1'b1)      $display("FAIL br_m_pc_en: got %b want 1", PC_en);   else n_pass++;
      n_checks++; if (ForwardRSD !== 3'd1) $display("FAIL br_rsd: got %0d want 1", ForwardRSD); else n_pass++;
      n_checks++; if (ForwardRTD !== 3'd0) $display("FAIL br_rtd: got %0d want 0", ForwardRTD); else n_pass++;
      tick();
   endtask

   task automatic test_jal_fwd();
      logic [31:0] jal, jr31;
      jal  = {6'h03, 26'h100};
      jr31 = r_ins('h08, 31, 0, 0);
      do_reset();
      drive(jr31, jal, 0, 0);
      n_checks++; if (PC_en !== 1'b1)      $display("FAIL jal_e_pc_en: got %b want 1", PC_en);   else n_pass++;
      n_checks++; if (ForwardRSD !== 3'd3) $display("FAIL jal_e_rsd: got %0d want 3", ForwardRSD); else n_pass++;
      tick();
      drive(jr31, 0, jal, 0);
      n_checks++; if (ForwardRSD !== 3'd4) $display("FAIL jal_m_rsd: got %0d want 4", ForwardRSD); else n_pass++;
      tick();
      drive(jr31, 0, 0, jal);
      n_checks++; if (ForwardRSD !== 3'd5) $display("FAIL jal_w_rsd: got %0d want 5", ForwardRSD); else n_pass++;
      tick();
   endtask

   task automatic test_md_stall();
      logic [31:0] mult, mflo;
      mult = r_ins('h18, 1, 2, 0);
      mflo = r_ins('h12, 0, 0, 3);
      do_reset();
      drive(mflo, mult, 0, 0);
      n_checks++; if (md_busy !== 1'b1) $display("FAIL md_start_busy: got %b want 1", md_busy); else n_pass++;
      n_checks++; if (PC_en !== 1'b0)   $display("FAIL md_start_pc_en: got %b want 0", PC_en);  else n_pass++;
      tick();
      for (int k = 0; k < MULT_LAT; k++) begin
         drive(mflo, 0, 0, 0);
         n_checks++; if (md_busy !== 1'b1) $display("FAIL md_busy_%0d: got %b want 1", k, md_busy); else n_pass++;
         n_checks++; if (PC_en !== 1'b0)   $display("FAIL md_pc_en_%0d: got %b want 0", k, PC_en);  else n_pass++;
         tick();
      end
      drive(mflo, 0, 0, 0);
      n_checks++; if (md_busy !== 1'b0)   $display("FAIL md_done_busy: got %b want 0", md_busy);  else n_pass++;
      n_checks++; if (PC_en !== 1'b1)     $display("FAIL md_done_pc_en: got %b want 1", PC_en);   else n_pass++;
      n_checks++; if (stall_cnt !== 8'd6) $display("FAIL md_stall_cnt: got %0d want 6", stall_cnt); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid_md();
      logic [31:0] div, mflo;
      div  = r_ins('h1A, 1, 2, 0);
      mflo = r_ins('h12, 0, 0, 3);
      do_reset();
      drive(mflo, div, 0, 0);
      tick();
      drive(mflo, 0, 0, 0);
      repeat (3) tick();
      n_checks++; if (md_busy !== 1'b1)   $display("FAIL rmd_busy_pre: got %b want 1", md_busy);  else n_pass++;
      n_checks++; if (stall_cnt !== 8'd4) $display("FAIL rmd_cnt_pre: got %0d want 4", stall_cnt); else n_pass++;
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (md_busy !== 1'b0)  $display("FAIL rmd_busy: got %b want 0", md_busy);     else n_pass++;
      n_checks++; if (stall_cnt !== '0)  $display("FAIL rmd_cnt: got %0d want 0", stall_cnt);   else n_pass++;
      n_checks++; if (PC_en !== 1'b1)    $display("FAIL rmd_pc_en: got %b want 1", PC_en);      else n_pass++;
      n_checks++; if (IR_E_clr !== 1'b0) $display("FAIL rmd_ir_e_clr: got %b want 0", IR_E_clr); else n_pass++;
      #1;
      reset = 1'b1;
      md_left = 0; stall_total = 0;
      drive(0, 0, 0, 0);
   endtask

   task automatic test_zero_and_store();
      do_reset();
      drive(r_ins('h21, 0, 0, 4), i_ins('h2B, 0, 0, 0), r_ins('h21, 1, 2, 0), r_ins('h21, 1, 2, 0));
      n_checks++;
      if ({ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, ForwardRTM} !== 15'd0)
         $display("FAIL zero_forwards: got %0d %0d %0d %0d %0d want all 0",
                  ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE, ForwardRTM);
      else n_pass++;
      n_checks++; if (PC_en !== 1'b1) $display("FAIL zero_pc_en: got %b want 1", PC_en); else n_pass++;
      drive(0, 0, i_ins('h2B, 8, 7, 0), i_ins('h23, 9, 7, 0));
      n_checks++; if (ForwardRTM !== 3'd2) $display("FAIL sw_lw_rtm: got %0d want 2", ForwardRTM); else n_pass++;
      drive(0, 0, i_ins('h2B, 8, 31, 0), {6'h03, 26'h10});
      n_checks++; if (ForwardRTM !== 3'd5) $display("FAIL sw_jal_rtm: got %0d want 5", ForwardRTM); else n_pass++;
      drive(0, 0, r_ins('h21, 7, 7, 3), i_ins('h23, 9, 7, 0));
      n_checks++; if (ForwardRTM !== 3'd0) $display("FAIL nosw_rtm: got %0d want 0", ForwardRTM); else n_pass++;
      tick();
   endtask

   task automatic test_random();
      exp_t x;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         drive(rand_ins(), rand_ins(), rand_ins(), rand_ins());
         x = model();
         n_checks++; if (PC_en !== !x.stall)     $display("FAIL rnd_pc_en[%0d]: got %b want %b", n, PC_en, !x.stall);     else n_pass++;
         n_checks++; if (IR_D_en !== !x.stall)   $display("FAIL rnd_ir_d_en[%0d]: got %b want %b", n, IR_D_en, !x.stall); else n_pass++;
         n_checks++; if (IR_E_clr !== x.stall)   $display("FAIL rnd_ir_e_clr[%0d]: got %b want %b", n, IR_E_clr, x.stall); else n_pass++;
         n_checks++; if (md_busy !== x.busy)     $display("FAIL rnd_md_busy[%0d]: got %b want %b", n, md_busy, x.busy);   else n_pass++;
         n_checks++; if (ForwardRSD !== 3'(x.rsd)) $display("FAIL rnd_rsd[%0d]: got %0d want %0d", n, ForwardRSD, x.rsd); else n_pass++;
         n_checks++; if (ForwardRTD !== 3'(x.rtd)) $display("FAIL rnd_rtd[%0d]: got %0d want %0d", n, ForwardRTD, x.rtd); else n_pass++;
         n_checks++; if (ForwardRSE !== 3'(x.rse)) $display("FAIL rnd_rse[%0d]: got %0d want %0d", n, ForwardRSE, x.rse); else n_pass++;
         n_checks++; if (ForwardRTE !== 3'(x.rte)) $display("FAIL rnd_rte[%0d]: got %0d want %0d", n, ForwardRTE, x.rte); else n_pass++;
         n_checks++; if (ForwardRTM !== 3'(x.rtm)) $display("FAIL rnd_rtm[%0d]: got %0d want %0d", n, ForwardRTM, x.rtm); else n_pass++;
         n_checks++; if (stall_cnt !== CNT_W'(stall_total))
            $display("FAIL rnd_stall_cnt[%0d]: got %0d want %0d", n, stall_cnt, stall_total); else n_pass++;
         tick();
      end
      drive(0, 0, 0, 0);
      n_checks++; if (stall_cnt !== CNT_W'(stall_total))
         $display("FAIL rnd_final_cnt: got %0d want %0d", stall_cnt, stall_total); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_fwd();
      test_jal_fwd();
      test_md_stall();
      test_reset_mid_md();
      test_zero_and_store();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
